// File: rtl/wbu_gpr_pkg.sv
// Shared types and sizes for the write-back stage and register file.
// Register count, index width and data width live here for all users.
package wbu_gpr_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int REG_NUM        = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = ISA_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]     reg_data_t;

    // One retired write waiting to be committed to the array.
    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } pend_t;

endpackage

// File: rtl/gpr_array.sv
// 32-entry register storage: one sync write port, three async reads.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i, ra{0,1,2}_i -> rd{0,1,2}_o.
module gpr_array
    import wbu_gpr_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  reg_data_t wdata_i,
    input  reg_addr_t ra0_i,
    input  reg_addr_t ra1_i,
    input  reg_addr_t ra2_i,
    output reg_data_t rd0_o,
    output reg_data_t rd1_o,
    output reg_data_t rd2_o
);

    reg_data_t mem_q [REG_NUM];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // x0 is masked on read so it reads zero whatever is stored.
    assign rd0_o = (ra0_i == '0) ? '0 : mem_q[ra0_i];
    assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/wbu_gpr.sv
// Write-back stage: pending slot, operand forwarding, debug port, retire count.
// Ports: wb_* handshake in, rs1/rs2 -> src1/src2, dbg_* access, retire_cnt, pend_valid.
module wbu_gpr
    import wbu_gpr_pkg::*;
#(
    // Reset value of the retire counter; 0 in normal use.
    parameter reg_data_t RETIRE_CNT_RST = '0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      wb_valid,
    output logic      wb_ready,
    input  reg_addr_t rd,
    input  reg_data_t srd,
    input  logic      gpr_w_en,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output reg_data_t src1,
    output reg_data_t src2,
    input  logic      dbg_valid,
    output logic      dbg_ready,
    input  logic      dbg_we,
    input  reg_addr_t dbg_addr,
    input  reg_data_t dbg_wdata,
    output reg_data_t dbg_rdata,
    output reg_data_t retire_cnt,
    output logic      pend_valid
);

    pend_t     pend_q, pend_d;
    reg_data_t cnt_q, cnt_d;
    reg_data_t dbg_rdata_q, dbg_rdata_d;

    logic      wb_fire, dbg_wr, dbg_rd;
    logic      arr_we;
    reg_addr_t arr_waddr;
    reg_data_t arr_wdata;
    reg_data_t arr_rs1, arr_rs2, arr_dbg;
    reg_data_t fwd_dbg;

    // Reads see the pending write before it reaches the array.
    function automatic reg_data_t fwd(reg_addr_t a, reg_data_t arr, pend_t p);
        if (a == '0) return '0;
        if (p.valid && (p.addr == a)) return p.data;
        return arr;
    endfunction

    assign wb_ready  = rst;
    assign wb_fire   = wb_valid & wb_ready;
    // Debug only gets the array when no write-back is in flight.
    assign dbg_ready = rst & ~pend_q.valid & ~wb_valid;
    assign dbg_wr    = dbg_valid & dbg_ready & dbg_we;
    assign dbg_rd    = dbg_valid & dbg_ready & ~dbg_we;

    always_comb begin
        pend_d.valid = wb_fire & gpr_w_en & (rd != '0);
        pend_d.addr  = rd;
        pend_d.data  = srd;
        cnt_d        = wb_fire ? cnt_q + 1'b1 : cnt_q;
        fwd_dbg      = fwd(dbg_addr, arr_dbg, pend_q);
        dbg_rdata_d  = dbg_rd ? fwd_dbg : dbg_rdata_q;
    end

    // Arbitration makes pending commit and debug write exclusive.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = pend_q.addr;
        arr_wdata = pend_q.data;
        if (pend_q.valid) begin
            arr_we = 1'b1;
        end else if (dbg_wr) begin
            arr_we    = 1'b1;
            arr_waddr = dbg_addr;
            arr_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= '0;
            cnt_q       <= RETIRE_CNT_RST;
            dbg_rdata_q <= '0;
        end else begin
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    gpr_array u_array (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .ra0_i   (rs1),
        .ra1_i   (rs2),
        .ra2_i   (dbg_addr),
        .rd0_o   (arr_rs1),
        .rd1_o   (arr_rs2),
        .rd2_o   (arr_dbg)
    );

    assign src1       = fwd(rs1, arr_rs1, pend_q);
    assign src2       = fwd(rs2, arr_rs2, pend_q);
    assign dbg_rdata  = dbg_rdata_q;
    assign retire_cnt = cnt_q;
    assign pend_valid = pend_q.valid;

endmodule

// File: tb/tb_wbu_gpr.sv
// Randomized and directed checks of wbu_gpr against an architectural model.
// Model: a register map updated at accept time, plus counter and debug data.
module tb_wbu_gpr;

    localparam logic [31:0] CNT_RST = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_ready;
    logic [4:0]  rd, rs1, rs2, dbg_addr;
    logic [31:0] srd, src1, src2, dbg_wdata, dbg_rdata, retire_cnt;
    logic        gpr_w_en, dbg_valid, dbg_ready, dbg_we, pend_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_reg [32];
    logic        m_pv;
    logic [31:0] m_cnt;
    logic [31:0] m_dbg;

    always #5 clk = ~clk;

    wbu_gpr #(.RETIRE_CNT_RST(CNT_RST)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .rd(rd), .srd(srd), .gpr_w_en(gpr_w_en),
        .rs1(rs1), .rs2(rs2), .src1(src1), .src2(src2),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
        .retire_cnt(retire_cnt), .pend_valid(pend_valid)
    );

    function automatic logic [31:0] mread(logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_reg[a];
    endfunction

    function automatic logic m_dbg_ready();
        return rst && !m_pv && !wb_valid;
    endfunction

    // Advance one clock; the model consumes the inputs seen before the edge.
    task automatic tick();
        logic fire, dr, wr;
        fire = rst && wb_valid;
        dr   = m_dbg_ready();
        wr   = fire && gpr_w_en && (rd != 5'd0);
        if (dbg_valid && dr && !dbg_we) m_dbg = mread(dbg_addr);
        if (dbg_valid && dr && dbg_we && dbg_addr != 5'd0)
            m_reg[dbg_addr] = dbg_wdata;
        if (wr) m_reg[rd] = srd;
        if (fire) m_cnt = m_cnt + 32'd1;
        m_pv = wr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; gpr_w_en = 0; rd = 0; srd = 0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0; wb_valid = 1; gpr_w_en = 1; rd = 5;
        srd = 32'hDEAD_BEEF; rs1 = 5; rs2 = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pv = 0; m_cnt = CNT_RST; m_dbg = 0;
        n_vec++;
        if (src1 !== 32'd0) begin
            n_err++; $display("FAIL reset_src1 got %h exp 0", src1);
        end
        n_vec++;
        if (retire_cnt !== CNT_RST) begin
            n_err++; $display("FAIL reset_cnt got %h exp %h", retire_cnt, CNT_RST);
        end
        n_vec++;
        if (wb_ready !== 1'b0 || dbg_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready got %b%b exp 00", wb_ready, dbg_ready);
        end
        n_vec++;
        if (pend_valid !== 1'b0 || dbg_rdata !== 32'd0) begin
            n_err++; $display("FAIL reset_pend got %b/%h exp 0/0", pend_valid, dbg_rdata);
        end
        idle_inputs();
        rst = 1;
        #1;
        n_vec++;
        if (wb_ready !== 1'b1) begin
            n_err++; $display("FAIL release_ready got %b exp 1", wb_ready);
        end
    endtask

    task automatic test_forward();
        wb_valid = 1; gpr_w_en = 1; rd = 3; srd = 32'h1234_5678;
        tick();
        idle_inputs();
        rs1 = 3; rs2 = 3;
        #1;
        n_vec++;
        if (src1 !== 32'h1234_5678 || src2 !== 32'h1234_5678 || pend_valid !== 1'b1) begin
            n_err++; $display("FAIL fwd_pend got %h %h %b exp 12345678 x2 pv1", src1, src2, pend_valid);
        end
        tick();
        n_vec++;
        if (src1 !== 32'h1234_5678 || src2 !== 32'h1234_5678 || pend_valid !== 1'b0) begin
            n_err++; $display("FAIL fwd_array got %h %h %b exp 12345678 x2 pv0", src1, src2, pend_valid);
        end
    endtask

    task automatic test_x0_nowrite();
        logic [31:0] c0, r7;
        c0 = m_cnt; r7 = mread(7);
        wb_valid = 1; gpr_w_en = 1; rd = 0; srd = 32'hFFFF_FFFF;
        tick();
        n_vec++;
        if (pend_valid !== 1'b0) begin
            n_err++; $display("FAIL x0_pend got %b exp 0", pend_valid);
        end
        gpr_w_en = 0; rd = 7; srd = 32'hAA;
        tick();
        idle_inputs();
        rs1 = 0; rs2 = 7;
        #1;
        n_vec++;
        if (pend_valid !== 1'b0 || src1 !== 32'd0 || src2 !== r7) begin
            n_err++; $display("FAIL x0_read got %b %h %h exp 0 0 %h", pend_valid, src1, src2, r7);
        end
        n_vec++;
        if (retire_cnt !== c0 + 32'd2) begin
            n_err++; $display("FAIL x0_cnt got %h exp %h", retire_cnt, c0 + 32'd2);
        end
    endtask

    task automatic test_back_to_back();
        rs1 = 9;
        for (int k = 1; k <= 3; k++) begin
            wb_valid = 1; gpr_w_en = 1; rd = 9; srd = 32'(k);
            tick();
            n_vec++;
            if (src1 !== 32'(k) || pend_valid !== 1'b1) begin
                n_err++; $display("FAIL b2b_%0d got %h pv %b exp %h", k, src1, pend_valid, k);
            end
        end
        idle_inputs();
        tick();
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9;
        tick();
        dbg_valid = 0;
        n_vec++;
        if (dbg_rdata !== 32'd3 || src1 !== 32'd3) begin
            n_err++; $display("FAIL b2b_final got %h %h exp 3", dbg_rdata, src1);
        end
    endtask

    task automatic test_debug();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 10; dbg_wdata = 32'h55;
        wb_valid = 1; gpr_w_en = 1; rd = 11; srd = 32'h77;
        #1;
        n_vec++;
        if (dbg_ready !== 1'b0) begin
            n_err++; $display("FAIL dbg_blocked got %b exp 0", dbg_ready);
        end
        tick();
        wb_valid = 0; gpr_w_en = 0;
        #1;
        n_vec++;
        if (dbg_ready !== 1'b0) begin
            n_err++; $display("FAIL dbg_pend_block got %b exp 0", dbg_ready);
        end
        tick();
        n_vec++;
        if (dbg_ready !== 1'b1) begin
            n_err++; $display("FAIL dbg_grant got %b exp 1", dbg_ready);
        end
        tick();
        dbg_we = 0;
        tick();
        dbg_valid = 0;
        n_vec++;
        if (dbg_rdata !== 32'h55) begin
            n_err++; $display("FAIL dbg_read got %h exp 55", dbg_rdata);
        end
        dbg_valid = 1; dbg_we = 1; dbg_addr = 0; dbg_wdata = 32'hBAD;
        tick();
        dbg_we = 0;
        tick();
        dbg_valid = 0;
        n_vec++;
        if (dbg_rdata !== 32'd0) begin
            n_err++; $display("FAIL dbg_x0 got %h exp 0", dbg_rdata);
        end
    endtask

    task automatic test_wrap();
        int steps;
        logic saw_max;
        steps = 0; saw_max = 0;
        idle_inputs();
        wb_valid = 1;
        while (m_cnt != 32'd0 && steps < 64) begin
            if (m_cnt == 32'hFFFF_FFFF) saw_max = 1;
            tick();
            steps++;
            n_vec++;
            if (retire_cnt !== m_cnt) begin
                n_err++; $display("FAIL wrap_cnt got %h exp %h", retire_cnt, m_cnt);
            end
        end
        idle_inputs();
        n_vec++;
        if (!saw_max || retire_cnt !== 32'd0) begin
            n_err++; $display("FAIL wrap_zero got %h exp 0 (max seen %b)", retire_cnt, saw_max);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wb_valid  = ($urandom_range(0, 2) == 0);
            gpr_w_en  = $urandom_range(0, 1);
            rd        = 5'($urandom_range(0, 31));
            srd       = $urandom;
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            dbg_valid = $urandom_range(0, 1);
            dbg_we    = $urandom_range(0, 1);
            dbg_addr  = 5'($urandom_range(0, 31));
            dbg_wdata = $urandom;
            #1;
            n_vec++;
            if (dbg_ready !== m_dbg_ready() || wb_ready !== 1'b1) begin
                n_err++; $display("FAIL rnd_ready got %b%b exp %b1", dbg_ready, wb_ready, m_dbg_ready());
            end
            tick();
            n_vec++;
            if (src1 !== mread(rs1) || src2 !== mread(rs2)) begin
                n_err++; $display("FAIL rnd_src got %h %h exp %h %h", src1, src2, mread(rs1), mread(rs2));
            end
            n_vec++;
            if (pend_valid !== m_pv || retire_cnt !== m_cnt || dbg_rdata !== m_dbg) begin
                n_err++; $display("FAIL rnd_state got %b %h %h exp %b %h %h",
                                  pend_valid, retire_cnt, dbg_rdata, m_pv, m_cnt, m_dbg);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_x0_nowrite();
        test_back_to_back();
        test_debug();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wbu_gpr.md
Name: wbu_gpr

Overview:
- Write-back stage and general-purpose register file, directly downstream of the EXU result/write-enable logic.
- Accepts one retiring instruction's result (srd, gpr_w_en, rd) per cycle through a valid/ready handshake.
- Holds the write for one cycle in a pending slot, then commits it to a 32-entry array.
- Serves two combinational operand reads (src1/src2) with forwarding from the pending slot, plus an arbitrated debug/difftest access port, and counts retired instructions.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired to zero)
REG_ADDR_WIDTH, 5, register index width
DATA_WIDTH, `ISA_WIDTH (32), register data width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
wb_valid  input  1  EXU presents a retiring instruction this cycle
wb_ready  output  1  stage can accept; constant 1 after reset release, 0 while rst asserted
rd  input  REG_ADDR_WIDTH  destination register index
srd  input  DATA_WIDTH  result to write
gpr_w_en  input  1  instruction writes rd
rs1  input  REG_ADDR_WIDTH  operand 1 index
rs2  input  REG_ADDR_WIDTH  operand 2 index
src1  output  DATA_WIDTH  operand 1 value (combinational)
src2  output  DATA_WIDTH  operand 2 value (combinational)
dbg_valid  input  1  debug access request
dbg_ready  output  1  debug access granted this cycle
dbg_we  input  1  1 = debug write, 0 = debug read
dbg_addr  input  REG_ADDR_WIDTH  debug register index
dbg_wdata  input  DATA_WIDTH  debug write data
dbg_rdata  output  DATA_WIDTH  debug read data, registered
retire_cnt  output  DATA_WIDTH  count of accepted wb transfers
pend_valid  output  1  pending slot occupied (observability)

Behaviour:
- Reset (rst=0, async): all array entries 0, pending slot cleared (pend_valid=0), retire_cnt=0, dbg_rdata=0, wb_ready=0, dbg_ready=0. A pending write at reset assertion is dropped.
- Accept: wb_fire = wb_valid & wb_ready. On wb_fire, retire_cnt increments by 1 and wraps at 2^DATA_WIDTH.
- Pending load: on wb_fire with gpr_w_en=1 and rd!=0, the pending slot loads {rd, srd} next edge and pend_valid=1. For any other wb_fire, or no fire, pend_valid=0 next edge.
- Commit: every edge with pend_valid=1 writes array[pend_addr] <= pend_data. Write latency is one cycle from acceptance to pending and two cycles to the array.
- Back-to-back: commit of the old pending entry and load of the new one happen on the same edge, giving one write per cycle sustained.
- Operand read (combinational), evaluated for src1 and src2 independently:
  - addr==0 gives 0.
  - Otherwise, if pend_valid and pend_addr==addr, gives pend_data.
  - Otherwise gives array[addr].
  - No forwarding from the same-cycle srd input; the hazard unit covers that case.
- Debug arbitration: dbg_ready = rst & ~pend_valid & ~wb_valid. Write-back always has priority over debug.
- Debug write (dbg_valid & dbg_ready & dbg_we): array[dbg_addr] <= dbg_wdata next edge. Writes to dbg_addr=0 are ignored.
- Debug read (dbg_valid & dbg_ready & ~dbg_we): dbg_rdata <= value read through the same forwarding mux next edge. Otherwise dbg_rdata holds its value.
- x0 is never written by any path and always reads 0.
- Only one writer reaches the array per edge; the arbitration guarantees this.

Decomposition:
- config.v defines `REG_NUM and `REG_ADDR_WIDTH, alongside the existing `ISA_WIDTH.
- One sub-module, gpr_array:
  - pure storage, one synchronous write port (we/waddr/wdata) and three async read ports;
  - async active-low reset clears all entries;
  - x0 masking is done in the sub-module.
- wbu_gpr holds the pending slot, forwarding muxes, debug arbiter, counter and write-port mux.

Test Plan:
- Reset: hold rst=0 with wb_valid=1, srd=0xDEADBEEF, rd=5 -> src1(rs1=5)=0, retire_cnt=0, wb_ready=0. Release -> wb_ready=1.
- Forwarding: accept rd=3, srd=0x12345678, gpr_w_en=1; next cycle rs1=rs2=3 -> both 0x12345678 with pend_valid=1. Following cycle, idle -> still 0x12345678 from the array, pend_valid=0.
- x0 and no-write: accept rd=0, srd=0xFFFFFFFF, gpr_w_en=1, then rd=7, gpr_w_en=0, srd=0xAA -> pend_valid stays 0, src(0)=0, src(7) unchanged. retire_cnt goes +2.
- Back-to-back same register: three consecutive fires to rd=9 with 1, 2, 3 -> rs1=9 reads 1, 2, 3 on the following cycles. Final array[9]=3.
- Debug arbitration: dbg_valid=1 write x10=0x55 while wb_valid=1 -> dbg_ready=0. After wb_valid drops and the pending slot drains -> dbg_ready=1; write lands, and a debug read of x10 gives dbg_rdata=0x55 one cycle later.
- Counter wrap: force 2^32 accepts (or preload via a test hook) -> retire_cnt wraps 0xFFFFFFFF to 0x00000000.
